// File: rtl/ialu_issue_queue_pkg.sv
// Shared types and constants for the integer ALU issue queue.
// Entry layout, tag-0 constant and wakeup bus unpacking.
package ialu_issue_queue_pkg;

  localparam int IQ_DEPTH      = 8;
  localparam int IQ_PREG_W     = 7;
  localparam int IQ_KILL_W     = 8;
  localparam int IQ_PAYLOAD_W  = 96;
  localparam int IQ_WAKE_PORTS = 4;

  localparam logic [IQ_PREG_W-1:0] IQ_TAG_ZERO = '0;

  typedef struct packed {
    logic [IQ_PAYLOAD_W-1:0] payload;
    logic [IQ_PREG_W-1:0]    prs1;
    logic [IQ_PREG_W-1:0]    prs2;
    logic                    rdy1;
    logic                    rdy2;
    logic [IQ_KILL_W-1:0]    killmask;
  } iq_entry_t;

  function automatic logic [IQ_PREG_W-1:0] wake_tag(
    input logic [IQ_WAKE_PORTS*IQ_PREG_W-1:0] bus,
    input int unsigned                        port
  );
    return bus[port*IQ_PREG_W +: IQ_PREG_W];
  endfunction

endpackage

// File: rtl/ialu_issue_queue_tag_match.sv
// Compares one source tag against every wakeup port.
// hit is set when any valid port carries the same tag.
module ialu_issue_queue_tag_match
  import ialu_issue_queue_pkg::*;
(
  input  logic [IQ_PREG_W-1:0]               tag,
  input  logic [IQ_WAKE_PORTS-1:0]           wake_valid,
  input  logic [IQ_WAKE_PORTS*IQ_PREG_W-1:0] wake_prd,
  output logic                               hit
);

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < IQ_WAKE_PORTS; i++) begin
      if (wake_valid[i] && wake_tag(wake_prd, i) == tag)
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/ialu_issue_queue.sv
// Collapsing age-ordered IALU issue queue, oldest-ready select.
// Define IALU_IQ_WAKE_BYPASS_EN for same-cycle wakeup-to-issue.
module ialu_issue_queue
  import ialu_issue_queue_pkg::*;
#(
  parameter int DEPTH      = IQ_DEPTH,
  parameter int PREG_W     = IQ_PREG_W,
  parameter int KILL_W     = IQ_KILL_W,
  parameter int PAYLOAD_W  = IQ_PAYLOAD_W,
  parameter int WAKE_PORTS = IQ_WAKE_PORTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Flush,
  input  logic                         Kill_Enable,
  input  logic [KILL_W-1:0]            Kill_VKillMask,
  input  logic                         Resolve_Enable,
  input  logic [KILL_W-1:0]            Resolve_Mask,
  input  logic                         Disp_Valid,
  output logic                         Disp_Ready,
  input  logic [PAYLOAD_W-1:0]         Disp_Payload,
  input  logic [PREG_W-1:0]            Disp_Prs1,
  input  logic [PREG_W-1:0]            Disp_Prs2,
  input  logic                         Disp_Rdy1,
  input  logic                         Disp_Rdy2,
  input  logic [KILL_W-1:0]            Disp_KillMask,
  input  logic [WAKE_PORTS-1:0]        Wake_Valid,
  input  logic [WAKE_PORTS*PREG_W-1:0] Wake_Prd,
  input  logic                         FU_Ready,
  output logic                         Issue_Valid,
  output logic [PAYLOAD_W-1:0]         Issue_Payload,
  output logic [PREG_W-1:0]            Issue_Prs1,
  output logic [PREG_W-1:0]            Issue_Prs2,
  output logic [KILL_W-1:0]            Issue_KillMask
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  iq_entry_t        q   [DEPTH];
  iq_entry_t        nxt [DEPTH];
  iq_entry_t        din;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [DEPTH-1:0] hit1, hit2, r1, r2;
  logic [DEPTH-1:0] killed, cand, keep;
  logic             dhit1, dhit2;
  logic             disp_kill, disp_ok;
  logic             found, issue;
  logic [IW-1:0]    sel;
  logic [KILL_W-1:0] clr;

  assign clr        = Resolve_Enable ? Resolve_Mask : '0;
  assign Disp_Ready = count < CW'(DEPTH);

  for (genvar g = 0; g < DEPTH; g++) begin : g_tm
    ialu_issue_queue_tag_match u_m1 (
      .tag       (q[g].prs1),
      .wake_valid(Wake_Valid),
      .wake_prd  (Wake_Prd),
      .hit       (hit1[g])
    );
    ialu_issue_queue_tag_match u_m2 (
      .tag       (q[g].prs2),
      .wake_valid(Wake_Valid),
      .wake_prd  (Wake_Prd),
      .hit       (hit2[g])
    );
  end

  ialu_issue_queue_tag_match u_d1 (
    .tag       (Disp_Prs1),
    .wake_valid(Wake_Valid),
    .wake_prd  (Wake_Prd),
    .hit       (dhit1)
  );
  ialu_issue_queue_tag_match u_d2 (
    .tag       (Disp_Prs2),
    .wake_valid(Wake_Valid),
    .wake_prd  (Wake_Prd),
    .hit       (dhit2)
  );

  // Kill uses the stored (pre-resolve) mask.
  always_comb begin
    killed = '0;
    cand   = '0;
    r1     = '0;
    r2     = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef IALU_IQ_WAKE_BYPASS_EN
      r1[i] = q[i].rdy1 | hit1[i];
      r2[i] = q[i].rdy2 | hit2[i];
`else
      r1[i] = q[i].rdy1;
      r2[i] = q[i].rdy2;
`endif
      killed[i] = Kill_Enable && |(q[i].killmask & Kill_VKillMask);
      cand[i]   = (CW'(i) < count) && r1[i] && r2[i] && !killed[i];
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign issue = !rst && !Flush && FU_Ready && found;

  always_comb begin
    Issue_Valid    = issue;
    Issue_Payload  = '0;
    Issue_Prs1     = '0;
    Issue_Prs2     = '0;
    Issue_KillMask = '0;
    if (issue) begin
      Issue_Payload  = q[sel].payload;
      Issue_Prs1     = q[sel].prs1;
      Issue_Prs2     = q[sel].prs2;
      Issue_KillMask = q[sel].killmask & ~clr;
    end
  end

  always_comb begin
    disp_kill = Kill_Enable && |(Disp_KillMask & Kill_VKillMask);
    disp_ok   = Disp_Valid && Disp_Ready && !disp_kill;

    din.payload  = Disp_Payload;
    din.prs1     = Disp_Prs1;
    din.prs2     = Disp_Prs2;
    din.rdy1     = Disp_Rdy1 || Disp_Prs1 == IQ_TAG_ZERO || dhit1;
    din.rdy2     = Disp_Rdy2 || Disp_Prs2 == IQ_TAG_ZERO || dhit2;
    din.killmask = Disp_KillMask & ~clr;
  end

  // Survivors compact toward index 0; dispatch lands behind them.
  always_comb begin
    int pos;
    pos  = 0;
    keep = '0;
    for (int i = 0; i < DEPTH; i++)
      nxt[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = (CW'(i) < count) && !killed[i] &&
                !(issue && sel == IW'(i));
      if (keep[i]) begin
        nxt[pos]          = q[i];
        nxt[pos].rdy1     = q[i].rdy1 | hit1[i];
        nxt[pos].rdy2     = q[i].rdy2 | hit2[i];
        nxt[pos].killmask = q[i].killmask & ~clr;
        pos++;
      end
    end
    if (disp_ok && pos < DEPTH) begin
      nxt[pos] = din;
      pos++;
    end
    count_nxt = CW'(pos);
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else begin
      count <= count_nxt;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= nxt[i];
    end
  end

endmodule

// File: tb/tb_ialu_issue_queue.sv
// Directed bench for ialu_issue_queue with hand-computed expectations.
// Covers reset, wakeup, full, kill, resolve and flush behaviour.
module tb_ialu_issue_queue;

`ifdef IALU_IQ_WAKE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Flush;
  logic        Kill_Enable;
  logic [7:0]  Kill_VKillMask;
  logic        Resolve_Enable;
  logic [7:0]  Resolve_Mask;
  logic        Disp_Valid;
  logic        Disp_Ready;
  logic [95:0] Disp_Payload;
  logic [6:0]  Disp_Prs1;
  logic [6:0]  Disp_Prs2;
  logic        Disp_Rdy1;
  logic        Disp_Rdy2;
  logic [7:0]  Disp_KillMask;
  logic [3:0]  Wake_Valid;
  logic [27:0] Wake_Prd;
  logic        FU_Ready;
  logic        Issue_Valid;
  logic [95:0] Issue_Payload;
  logic [6:0]  Issue_Prs1;
  logic [6:0]  Issue_Prs2;
  logic [7:0]  Issue_KillMask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ialu_issue_queue dut (
    .clk           (clk),
    .rst           (rst),
    .Flush         (Flush),
    .Kill_Enable   (Kill_Enable),
    .Kill_VKillMask(Kill_VKillMask),
    .Resolve_Enable(Resolve_Enable),
    .Resolve_Mask  (Resolve_Mask),
    .Disp_Valid    (Disp_Valid),
    .Disp_Ready    (Disp_Ready),
    .Disp_Payload  (Disp_Payload),
    .Disp_Prs1     (Disp_Prs1),
    .Disp_Prs2     (Disp_Prs2),
    .Disp_Rdy1     (Disp_Rdy1),
    .Disp_Rdy2     (Disp_Rdy2),
    .Disp_KillMask (Disp_KillMask),
    .Wake_Valid    (Wake_Valid),
    .Wake_Prd      (Wake_Prd),
    .FU_Ready      (FU_Ready),
    .Issue_Valid   (Issue_Valid),
    .Issue_Payload (Issue_Payload),
    .Issue_Prs1    (Issue_Prs1),
    .Issue_Prs2    (Issue_Prs2),
    .Issue_KillMask(Issue_KillMask)
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [95:0] p, input logic [6:0] p1,
                      input logic [6:0] p2, input logic rd1,
                      input logic rd2, input logic [7:0] km);
    Disp_Valid    = 1'b1;
    Disp_Payload  = p;
    Disp_Prs1     = p1;
    Disp_Prs2     = p2;
    Disp_Rdy1     = rd1;
    Disp_Rdy2     = rd2;
    Disp_KillMask = km;
    step();
    Disp_Valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; Flush = 1'b0;
    Kill_Enable = 1'b0; Kill_VKillMask = '0;
    Resolve_Enable = 1'b0; Resolve_Mask = '0;
    Disp_Valid = 1'b0; Disp_Payload = '0;
    Disp_Prs1 = '0; Disp_Prs2 = '0;
    Disp_Rdy1 = 1'b0; Disp_Rdy2 = 1'b0; Disp_KillMask = '0;
    Wake_Valid = '0; Wake_Prd = '0;
    FU_Ready = 1'b1;

    step(); step(); #1;
    check("rst_iv", 128'(Issue_Valid), 128'(1'b0));
    check("rst_pay", 128'(Issue_Payload), 128'(96'h0));
    rst = 1'b0;
    step(); #1;
    check("post_rst_drdy", 128'(Disp_Ready), 128'(1'b1));
    check("post_rst_iv", 128'(Issue_Valid), 128'(1'b0));

    // A: both tags zero, issues the cycle after dispatch
    disp(96'hA1, 7'd0, 7'd0, 1'b0, 1'b0, 8'h00); #1;
    check("a_iv", 128'(Issue_Valid), 128'(1'b1));
    check("a_pay", 128'(Issue_Payload), 128'(96'hA1));
    step(); #1;
    check("a_empty", 128'(Issue_Valid), 128'(1'b0));

    // B: waits for tag 5 woken on port 0
    disp(96'hB2, 7'd5, 7'd0, 1'b0, 1'b1, 8'h00); #1;
    check("b_wait", 128'(Issue_Valid), 128'(1'b0));
    step();
    Wake_Valid = 4'b0001; Wake_Prd = 28'd5; #1;
    check("b_wake_cyc", 128'(Issue_Valid), 128'(BYP));
    step();
    Wake_Valid = '0; Wake_Prd = '0; #1;
    check("b_next_iv", 128'(Issue_Valid), 128'(!BYP));
    check("b_next_pay", 128'(Issue_Payload), 128'(BYP ? 96'h0 : 96'hB2));
    check("b_next_prs1", 128'(Issue_Prs1), 128'(BYP ? 7'd0 : 7'd5));
    step(); #1;
    check("b_empty", 128'(Issue_Valid), 128'(1'b0));

    // C: woken on port 3 while being dispatched
    Wake_Valid = 4'b1000; Wake_Prd = {7'd9, 21'd0};
    disp(96'hC3, 7'd0, 7'd9, 1'b1, 1'b0, 8'h00);
    Wake_Valid = '0; Wake_Prd = '0; #1;
    check("c_iv", 128'(Issue_Valid), 128'(1'b1));
    check("c_pay", 128'(Issue_Payload), 128'(96'hC3));
    check("c_prs2", 128'(Issue_Prs2), 128'(7'd9));
    step();

    // Fill to DEPTH with issue stalled
    FU_Ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fill_drdy", 128'(Disp_Ready), 128'(1'b1));
      disp(96'(16 + i), 7'd0, 7'd0, 1'b1, 1'b1, 8'h00);
    end
    #1;
    check("full_drdy", 128'(Disp_Ready), 128'(1'b0));
    check("full_iv", 128'(Issue_Valid), 128'(1'b0));
    FU_Ready = 1'b1; Disp_Valid = 1'b1; Disp_Payload = 96'hFF; #1;
    check("full_iss_iv", 128'(Issue_Valid), 128'(1'b1));
    check("full_iss_pay", 128'(Issue_Payload), 128'(96'h10));
    check("full_iss_drdy", 128'(Disp_Ready), 128'(1'b0));
    step();
    Disp_Valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      #1;
      check("drain_iv", 128'(Issue_Valid), 128'(1'b1));
      check("drain_pay", 128'(Issue_Payload), 128'(96'(16 + i)));
      step();
    end
    #1;
    check("drain_empty", 128'(Issue_Valid), 128'(1'b0));

    // Kill 0x02 removes outer entries and a same-cycle dispatch
    FU_Ready = 1'b0;
    disp(96'h40, 7'd0, 7'd0, 1'b1, 1'b1, 8'h02);
    disp(96'h41, 7'd0, 7'd0, 1'b1, 1'b1, 8'h00);
    disp(96'h42, 7'd0, 7'd0, 1'b1, 1'b1, 8'h02);
    Kill_Enable = 1'b1; Kill_VKillMask = 8'h02;
    Disp_Valid = 1'b1; Disp_Payload = 96'h43; Disp_KillMask = 8'h02; #1;
    check("kill_iv_stall", 128'(Issue_Valid), 128'(1'b0));
    step();
    Kill_Enable = 1'b0; Disp_Valid = 1'b0; Disp_KillMask = 8'h00;
    FU_Ready = 1'b1; #1;
    check("kill_iv", 128'(Issue_Valid), 128'(1'b1));
    check("kill_pay", 128'(Issue_Payload), 128'(96'h41));
    step(); #1;
    check("kill_empty", 128'(Issue_Valid), 128'(1'b0));

    // Select skips a killed oldest entry in the same cycle
    FU_Ready = 1'b0;
    disp(96'h50, 7'd0, 7'd0, 1'b1, 1'b1, 8'h01);
    disp(96'h51, 7'd0, 7'd0, 1'b1, 1'b1, 8'h00);
    Kill_Enable = 1'b1; Kill_VKillMask = 8'h01; FU_Ready = 1'b1; #1;
    check("skip_iv", 128'(Issue_Valid), 128'(1'b1));
    check("skip_pay", 128'(Issue_Payload), 128'(96'h51));
    step();
    Kill_Enable = 1'b0; #1;
    check("skip_empty", 128'(Issue_Valid), 128'(1'b0));

    // Resolve 0x04 then kill 0x04: entry survives with mask 0x02
    FU_Ready = 1'b0;
    disp(96'h60, 7'd0, 7'd0, 1'b1, 1'b1, 8'h06);
    Resolve_Enable = 1'b1; Resolve_Mask = 8'h04;
    step();
    Resolve_Enable = 1'b0;
    Kill_Enable = 1'b1; Kill_VKillMask = 8'h04; FU_Ready = 1'b1; #1;
    check("res_iv", 128'(Issue_Valid), 128'(1'b1));
    check("res_km", 128'(Issue_KillMask), 128'(8'h02));
    step();
    Kill_Enable = 1'b0; #1;
    check("res_empty", 128'(Issue_Valid), 128'(1'b0));

    // Same-cycle resolve is reflected on Issue_KillMask
    FU_Ready = 1'b0;
    disp(96'h62, 7'd0, 7'd0, 1'b1, 1'b1, 8'h30);
    Resolve_Enable = 1'b1; Resolve_Mask = 8'h10; FU_Ready = 1'b1; #1;
    check("res_bypass_km", 128'(Issue_KillMask), 128'(8'h20));
    step();
    Resolve_Enable = 1'b0;

    // Kill and resolve together: kill sees the pre-resolve mask
    FU_Ready = 1'b0;
    disp(96'h61, 7'd0, 7'd0, 1'b1, 1'b1, 8'h04);
    Kill_Enable = 1'b1; Kill_VKillMask = 8'h04;
    Resolve_Enable = 1'b1; Resolve_Mask = 8'h04;
    step();
    Kill_Enable = 1'b0; Resolve_Enable = 1'b0; FU_Ready = 1'b1; #1;
    check("kill_res_iv", 128'(Issue_Valid), 128'(1'b0));

    // Flush with 5 entries and a concurrent dispatch
    FU_Ready = 1'b0;
    for (int i = 0; i < 5; i++)
      disp(96'(112 + i), 7'd0, 7'd0, 1'b1, 1'b1, 8'h00);
    Flush = 1'b1; FU_Ready = 1'b1;
    Disp_Valid = 1'b1; Disp_Payload = 96'h7F; #1;
    check("flush_iv", 128'(Issue_Valid), 128'(1'b0));
    step();
    Flush = 1'b0; Disp_Valid = 1'b0; #1;
    check("flush_drdy", 128'(Disp_Ready), 128'(1'b1));
    check("flush_empty", 128'(Issue_Valid), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
